ram_pair_scheduler: RTL
=======================

Name: ram_pair_scheduler

Overview:
- Sequences and shares the pair of 512x8 single-port RAMs that sit behind the sum/difference butterfly (RAM0 <- q0+q1, RAM1 <- q0-q1).
- Two requesters:
  - a sweep engine that applies the butterfly read-modify-write over an address range;
  - a host port for single-word reads and writes to either RAM.
- Owns the shared RAM address, data and write-enable buses. Sits between the top-level FSM/switch logic and the RAM instances.

Parameters:
- ADDR_W, 9, RAM address width (depth 2^ADDR_W).
- DATA_W, 8, RAM word width.

Ports:
- CLOCK_50_I  in  1  system clock, 50 MHz.
- resetn  in  1  asynchronous, active-low reset.
- sweep_start  in  1  start request; sampled only in S_IDLE.
- sweep_first_addr  in  ADDR_W  first address of the sweep.
- sweep_last_addr  in  ADDR_W  last address of the sweep (inclusive).
- sweep_busy  out  1  sweep in progress.
- sweep_done  out  1  one-cycle completion pulse.
- host_req  in  1  host access request; hold until host_gnt.
- host_we  in  1  1=write, 0=read.
- host_sel  in  1  target RAM (0/1).
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_gnt  out  1  one-cycle grant; the access executes in this cycle.
- host_rvalid  out  1  read data valid.
- host_rdata  out  DATA_W  read data.
- ram_address  out  ADDR_W  shared address to both RAMs.
- ram_wdata0, ram_wdata1  out  DATA_W  write data to RAM0 and RAM1.
- ram_wren0, ram_wren1  out  1  write enables.
- ram_q0, ram_q1  in  DATA_W  RAM read data; valid the cycle after the address is captured.

Behaviour:
- Reset:
  - state=S_IDLE.
  - All outputs are 0: busy, done, gnt, rvalid, rdata, address, wdata, wren.
  - Latched sweep and host registers are cleared.
  - Reset mid-sweep abandons the sweep with no done pulse. A RAM write already captured is not undone.
- RAMs capture address, data and wren on the rising edge; read latency is 1 cycle.
- ram_* outputs are decoded combinationally from the registered state and registers:
  - S_HOST: address=host_addr_q; wren[host_sel_q]=host_we_q; wdata=host_wdata_q.
  - S_SWEEP_READ: address=sweep_addr; wren=0.
  - S_SWEEP_WRITE: address=sweep_addr; wren0=wren1=1.
    - wdata0 = ram_q0+ram_q1, wdata1 = ram_q0-ram_q1.
    - Both are mod 2^DATA_W; carry and borrow are discarded.
  - S_IDLE: address, wdata and wren are all 0.
- States and transitions:
  - S_IDLE:
    - On sweep_start: latch first/last, set sweep_addr=first, sweep_active=1.
    - If first>last: pulse sweep_done next cycle, no RAM access, stay idle.
    - Then decide (see below).
  - S_HOST: lasts 1 cycle; host_gnt=1. host_req is ignored at the edge that ends S_HOST.
    - Next state is S_SWEEP_READ if sweep_active, else S_IDLE.
  - S_SWEEP_READ -> S_SWEEP_WRITE, always.
  - S_SWEEP_WRITE:
    - If sweep_addr==last: clear sweep_active, pulse done in the next cycle.
    - Else: sweep_addr+1.
    - Then decide (see below).
- Decision rule (used in S_IDLE and at the end of S_SWEEP_WRITE):
  - host_req=1 -> latch host fields, go to S_HOST.
  - Else if sweep_active -> S_SWEEP_READ.
  - Else -> S_IDLE.
  - Fairness: at most one host access between sweep elements. The host worst-case wait is 2 cycles.
- Simultaneous sweep_start and host_req in S_IDLE: the sweep is latched and the host is served first.
- sweep_start while busy is ignored.
- sweep_busy is high from the cycle after start acceptance through the final S_SWEEP_WRITE, including interleaved S_HOST cycles.
- Host reads:
  - host_rvalid=1 in the cycle after S_HOST.
  - host_rdata = host_sel_q ? ram_q1 : ram_q0, registered into host_rdata on that cycle's edge and held until the next read.
- Address counter: compares for equality with last, so last=2^ADDR_W-1 finishes without wrap.

Decomposition:
- Package ram_pair_pkg holds:
  - the state enum {S_IDLE, S_HOST, S_SWEEP_READ, S_SWEEP_WRITE};
  - the ADDR_W and DATA_W defaults.
- Sub-module ram_pair_butterfly (combinational sum/difference, DATA_W wide) produces the sweep write data.
- The FSM, arbiter and host/sweep registers stay in ram_pair_scheduler.

Test Plan:
- Reset asserted mid-run -> every output 0 the same cycle; after release, state idle; no done pulse.
- Host writes RAM0[5]=0x12 and RAM1[5]=0x07, then reads each back -> gnt 1 cycle per access; rvalid the cycle after gnt; rdata 0x12 and 0x07.
- Sweep first=last=5 on those values -> RAM0[5]=0x19, RAM1[5]=0x0B; busy for 2 cycles; done pulses the following cycle.
- Overflow and borrow: RAM0[9]=0xF0, RAM1[9]=0x20 -> 0x10 and 0xD0; RAM0[10]=0x05, RAM1[10]=0x09 -> 0x0E and 0xFC.
- Full sweep 0..511 with host_req held high on reads -> strict H,R,W interleave; 512 host grants; done 1536 cycles after start; all 512 words transformed.
- sweep_start with first=20, last=10 -> done 1 cycle later, no wren. Separately, reset at sweep_addr=100 -> busy drops, no done, addresses 100..511 unchanged.

Source files
------------

// File: rtl/ram_pair_pkg.sv
// Shared types and default widths for the butterfly RAM-pair scheduler.
package ram_pair_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOST,
    S_SWEEP_READ,
    S_SWEEP_WRITE
  } state_e;

endpackage

// File: rtl/ram_pair_butterfly.sv
// Combinational sum/difference butterfly; results wrap modulo 2^DATA_W.
module ram_pair_butterfly #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum,
  output logic [DATA_W-1:0] diff
);

  assign sum  = a + b;
  assign diff = a - b;

endmodule

// File: rtl/ram_pair_scheduler.sv
// Arbitrates the shared RAM0/RAM1 buses between a butterfly sweep engine and
// a single-word host port; one host access is allowed between sweep elements.
module ram_pair_scheduler
  import ram_pair_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              CLOCK_50_I,
  input  logic              resetn,
  input  logic              sweep_start,
  input  logic [ADDR_W-1:0] sweep_first_addr,
  input  logic [ADDR_W-1:0] sweep_last_addr,
  output logic              sweep_busy,
  output logic              sweep_done,
  input  logic              host_req,
  input  logic              host_we,
  input  logic              host_sel,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_wdata0,
  output logic [DATA_W-1:0] ram_wdata1,
  output logic              ram_wren0,
  output logic              ram_wren1,
  input  logic [DATA_W-1:0] ram_q0,
  input  logic [DATA_W-1:0] ram_q1
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   sweep_addr_q, sweep_addr_d;
  logic [ADDR_W-1:0]   sweep_last_q, sweep_last_d;
  logic                sweep_active_q, sweep_active_d;
  logic                host_we_q, host_we_d;
  logic                host_sel_q, host_sel_d;
  logic [ADDR_W-1:0]   host_addr_q, host_addr_d;
  logic [DATA_W-1:0]   host_wdata_q, host_wdata_d;
  logic                done_q, done_d;
  logic                rd_pending_q, rd_pending_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                decide;
  logic [DATA_W-1:0]   bf_sum, bf_diff;
  logic [DATA_W-1:0]   rd_word;

  ram_pair_butterfly #(.DATA_W(DATA_W)) u_butterfly (
    .a    (ram_q0),
    .b    (ram_q1),
    .sum  (bf_sum),
    .diff (bf_diff)
  );

  assign rd_word = host_sel_q ? ram_q1 : ram_q0;

  always_comb begin
    state_d        = state_q;
    sweep_addr_d   = sweep_addr_q;
    sweep_last_d   = sweep_last_q;
    sweep_active_d = sweep_active_q;
    host_we_d      = host_we_q;
    host_sel_d     = host_sel_q;
    host_addr_d    = host_addr_q;
    host_wdata_d   = host_wdata_q;
    done_d         = 1'b0;
    rd_pending_d   = 1'b0;
    rdata_d        = rdata_q;
    decide         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (sweep_start) begin
          sweep_addr_d = sweep_first_addr;
          sweep_last_d = sweep_last_addr;
          // An inverted range completes immediately without touching the RAMs.
          if (sweep_first_addr > sweep_last_addr) begin
            done_d = 1'b1;
          end else begin
            sweep_active_d = 1'b1;
          end
        end
        decide = 1'b1;
      end
      S_HOST: begin
        rd_pending_d = ~host_we_q;
        state_d      = sweep_active_q ? S_SWEEP_READ : S_IDLE;
      end
      S_SWEEP_READ: begin
        state_d = S_SWEEP_WRITE;
      end
      S_SWEEP_WRITE: begin
        if (sweep_addr_q == sweep_last_q) begin
          sweep_active_d = 1'b0;
          done_d         = 1'b1;
        end else begin
          sweep_addr_d = sweep_addr_q + ADDR_ONE;
        end
        decide = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (decide) begin
      if (host_req) begin
        host_we_d    = host_we;
        host_sel_d   = host_sel;
        host_addr_d  = host_addr;
        host_wdata_d = host_wdata;
        state_d      = S_HOST;
      end else if (sweep_active_d) begin
        state_d = S_SWEEP_READ;
      end else begin
        state_d = S_IDLE;
      end
    end

    if (rd_pending_q) begin
      rdata_d = rd_word;
    end
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state_q        <= S_IDLE;
      sweep_addr_q   <= '0;
      sweep_last_q   <= '0;
      sweep_active_q <= 1'b0;
      host_we_q      <= 1'b0;
      host_sel_q     <= 1'b0;
      host_addr_q    <= '0;
      host_wdata_q   <= '0;
      done_q         <= 1'b0;
      rd_pending_q   <= 1'b0;
      rdata_q        <= '0;
    end else begin
      state_q        <= state_d;
      sweep_addr_q   <= sweep_addr_d;
      sweep_last_q   <= sweep_last_d;
      sweep_active_q <= sweep_active_d;
      host_we_q      <= host_we_d;
      host_sel_q     <= host_sel_d;
      host_addr_q    <= host_addr_d;
      host_wdata_q   <= host_wdata_d;
      done_q         <= done_d;
      rd_pending_q   <= rd_pending_d;
      rdata_q        <= rdata_d;
    end
  end

  always_comb begin
    ram_address = '0;
    ram_wdata0  = '0;
    ram_wdata1  = '0;
    ram_wren0   = 1'b0;
    ram_wren1   = 1'b0;
    case (state_q)
      S_HOST: begin
        ram_address = host_addr_q;
        ram_wdata0  = host_wdata_q;
        ram_wdata1  = host_wdata_q;
        ram_wren0   = host_we_q & ~host_sel_q;
        ram_wren1   = host_we_q & host_sel_q;
      end
      S_SWEEP_READ: begin
        ram_address = sweep_addr_q;
      end
      S_SWEEP_WRITE: begin
        ram_address = sweep_addr_q;
        ram_wdata0  = bf_sum;
        ram_wdata1  = bf_diff;
        ram_wren0   = 1'b1;
        ram_wren1   = 1'b1;
      end
      default: ;
    endcase
  end

  // Read data is forwarded live while valid, then held from the register.
  assign host_rdata  = rd_pending_q ? rd_word : rdata_q;
  assign host_rvalid = rd_pending_q;
  assign host_gnt    = (state_q == S_HOST);
  assign sweep_busy  = sweep_active_q;
  assign sweep_done  = done_q;

endmodule
